// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the memory controller IC port.
// A miss parks in MISS until the controller acks; jp_wrong abandons the pending result but keeps the fill.
module icache_direct #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned ADDR_BITS  = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        jp_wrong,
  input  logic        if_req_flag,
  input  logic [31:0] if_pc,
  output logic        inst_out_flag,
  output logic [31:0] inst_out,
  output logic [31:0] inst_out_pc,
  output logic        mem_req_flag,
  output logic [31:0] mem_addr,
  input  logic        mem_ack_flag,
  input  logic [31:0] mem_data
);
  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = ADDR_BITS - INDEX_BITS - 2;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                state_q, state_d;
  logic [31:2]           miss_pc_q, miss_pc_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic                  out_flag_q, out_flag_d;
  logic [31:0]           inst_out_q, inst_out_d;
  logic [31:0]           out_pc_q, out_pc_d;

  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];

  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]      req_tag, fill_tag;
  logic                  hit, fill;
  logic                  unused_pc_bits;

  assign req_idx  = if_pc[INDEX_BITS+1:2];
  assign req_tag  = if_pc[ADDR_BITS-1:INDEX_BITS+2];
  assign fill_idx = miss_pc_q[INDEX_BITS+1:2];
  assign fill_tag = miss_pc_q[ADDR_BITS-1:INDEX_BITS+2];
  assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign unused_pc_bits = ^if_pc[1:0];

  assign mem_req_flag  = (state_q == MISS) && !mem_ack_flag;
  assign mem_addr      = {miss_pc_q, 2'b00};
  assign inst_out_flag = out_flag_q;
  assign inst_out      = inst_out_q;
  assign inst_out_pc   = out_pc_q;

  always_comb begin
    state_d    = state_q;
    miss_pc_d  = miss_pc_q;
    out_flag_d = 1'b0;
    inst_out_d = inst_out_q;
    out_pc_d   = out_pc_q;
    fill       = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req_flag) begin
          if (hit) begin
            out_flag_d = 1'b1;
            inst_out_d = data_mem[req_idx];
            out_pc_d   = {if_pc[31:2], 2'b00};
          end else begin
            miss_pc_d = if_pc[31:2];
            state_d   = MISS;
          end
        end
      end
      MISS: begin
        if (mem_ack_flag) begin
          fill       = 1'b1;
          out_flag_d = 1'b1;
          inst_out_d = mem_data;
          out_pc_d   = {miss_pc_q, 2'b00};
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A flush suppresses the response but a coincident fill still lands: the data matches miss_pc.
    if (jp_wrong) begin
      state_d    = IDLE;
      out_flag_d = 1'b0;
      inst_out_d = inst_out_q;
      out_pc_d   = out_pc_q;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (fill) valid_d[fill_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      miss_pc_q  <= '0;
      valid_q    <= '0;
      out_flag_q <= 1'b0;
      inst_out_q <= '0;
      out_pc_q   <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      miss_pc_q  <= miss_pc_d;
      valid_q    <= valid_d;
      out_flag_q <= out_flag_d;
      inst_out_q <= inst_out_d;
      out_pc_q   <= out_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_data;
    end
  end
endmodule
